// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle between the issue stage, alu_arbiter and the alu.
// slave is the arbiter side, master is the issue/ALU/consumer side.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [5:0]            req0_op;
  logic [DATA_WIDTH-1:0] req0_x;
  logic [DATA_WIDTH-1:0] req0_y;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [5:0]            req1_op;
  logic [DATA_WIDTH-1:0] req1_x;
  logic [DATA_WIDTH-1:0] req1_y;
  logic [5:0]            alu_op;
  logic [DATA_WIDTH-1:0] alu_x;
  logic [DATA_WIDTH-1:0] alu_y;
  logic [DATA_WIDTH-1:0] alu_w;
  logic                  alu_cmp;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_w;
  logic                  rsp_cmp;
  logic                  rsp_err;
  logic                  busy;

  modport slave (
    input  req0_valid, req0_op, req0_x, req0_y,
    input  req1_valid, req1_op, req1_x, req1_y,
    input  alu_w, alu_cmp, rsp_ready,
    output req0_ready, req1_ready, alu_op, alu_x, alu_y,
    output rsp_valid, rsp_id, rsp_w, rsp_cmp, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_op, req0_x, req0_y,
    output req1_valid, req1_op, req1_x, req1_y,
    output alu_w, alu_cmp, rsp_ready,
    input  req0_ready, req1_ready, alu_op, alu_x, alu_y,
    input  rsp_valid, rsp_id, rsp_w, rsp_cmp, rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with multi-cycle MUL hold.
// Optional feature macro: ALU_ARB_ILLEGAL_OP_EN (illegal opcodes answered with rsp_err, no EXEC).
module alu_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [5:0] OP_MUL  = 6'h02;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LATENCY - 1);

  function automatic logic is_cmp_op(input logic [5:0] op);
    return (op == 6'h09) || (op == 6'h0A) || (op == 6'h0B);
  endfunction

`ifdef ALU_ARB_ILLEGAL_OP_EN
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op <= 6'h07) || ((op >= 6'h09) && (op <= 6'h0C));
  endfunction
`endif

  state_t                state_r, next_s;
  logic [3:0]            cnt_r;
  logic                  last_grant_r;
  logic [5:0]            alu_op_r;
  logic [DATA_WIDTH-1:0] alu_x_r, alu_y_r;
  logic                  rsp_id_r, rsp_cmp_r, rsp_err_r;
  logic [DATA_WIDTH-1:0] rsp_w_r;

  logic                  grant_s, grant_id_s, illegal_s;
  logic                  req0_ready_s, req1_ready_s;
  logic [5:0]            sel_op_s;
  logic [DATA_WIDTH-1:0] sel_x_s, sel_y_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state, round-robin grant and ready generation
  always_comb begin
    next_s       = state_r;
    grant_s      = 1'b0;
    grant_id_s   = 1'b0;
    req0_ready_s = 1'b0;
    req1_ready_s = 1'b0;
    // On a tie the requester that did not win last time is chosen.
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id_s = ~last_grant_r;
    end else begin
      grant_id_s = bus.req1_valid;
    end
    sel_op_s = grant_id_s ? bus.req1_op : bus.req0_op;
    sel_x_s  = grant_id_s ? bus.req1_x  : bus.req0_x;
    sel_y_s  = grant_id_s ? bus.req1_y  : bus.req0_y;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    illegal_s = ~is_legal_op(sel_op_s);
`else
    illegal_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
          grant_s      = 1'b1;
          req0_ready_s = ~grant_id_s;
          req1_ready_s = grant_id_s;
          next_s       = illegal_s ? RESP : EXEC;
        end else begin
          next_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == 4'd0) begin
          next_s = RESP;
        end else begin
          next_s = EXEC;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          next_s = IDLE;
        end else begin
          next_s = RESP;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // Operand latch at accept, cycle countdown and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= 4'd0;
      last_grant_r <= 1'b1;
      alu_op_r     <= 6'h00;
      alu_x_r      <= '0;
      alu_y_r      <= '0;
      rsp_id_r     <= 1'b0;
      rsp_w_r      <= '0;
      rsp_cmp_r    <= 1'b0;
      rsp_err_r    <= 1'b0;
    end else if (grant_s) begin
      last_grant_r <= grant_id_s;
      alu_op_r     <= sel_op_s;
      alu_x_r      <= sel_x_s;
      alu_y_r      <= sel_y_s;
      rsp_id_r     <= grant_id_s;
      cnt_r        <= (sel_op_s == OP_MUL) ? MUL_CNT : 4'd0;
      rsp_err_r    <= illegal_s;
      if (illegal_s) begin
        rsp_w_r   <= '0;
        rsp_cmp_r <= 1'b0;
      end
    end else if (state_r == EXEC) begin
      if (cnt_r == 4'd0) begin
        // Compare ops report only the flag; everything else only the word.
        rsp_w_r   <= is_cmp_op(alu_op_r) ? '0 : bus.alu_w;
        rsp_cmp_r <= is_cmp_op(alu_op_r) ? bus.alu_cmp : 1'b0;
      end else begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  assign bus.req0_ready = req0_ready_s;
  assign bus.req1_ready = req1_ready_s;
  assign bus.alu_op     = alu_op_r;
  assign bus.alu_x      = alu_x_r;
  assign bus.alu_y      = alu_y_r;
  assign bus.rsp_valid  = (state_r == RESP);
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_w      = rsp_w_r;
  assign bus.rsp_cmp    = rsp_cmp_r;
  assign bus.rsp_err    = rsp_err_r;
  assign bus.busy       = (state_r != IDLE);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle combinational `alu` between two issue requesters (integer pipe and address-generation pipe) and sequences multi-cycle MUL. Each request is accepted with a valid/ready handshake, and its operands are held stable on the ALU for the required number of cycles. The result is then returned on one response channel tagged with the requester ID. The block sits between the issue stage and the `alu` instance.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; must equal `REG_FILE_WIDTH`
- MUL_LATENCY, 3, cycles operands are held for op 0x02; legal range 1..15

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid, req1_valid  in  1  request present
- req0_ready, req1_ready  out  1  request accepted this cycle
- req0_op, req1_op  in  6  ALU opcode
- req0_x, req0_y, req1_x, req1_y  in  DATA_WIDTH  operands
- alu_op  out  6  opcode driven to ALU
- alu_x, alu_y  out  DATA_WIDTH  operands driven to ALU
- alu_w  in  DATA_WIDTH  ALU result
- alu_cmp  in  1  ALU compare flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester of response (0/1)
- rsp_w  out  DATA_WIDTH  result
- rsp_cmp  out  1  compare result
- rsp_err  out  1  illegal opcode flag (see Configuration)
- busy  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: no transaction held.
  - EXEC: operands driven; down-counter cnt runs.
  - RESP: result held on rsp_*.
- IDLE: if any reqN_valid, grant one requester.
  - Assert its reqN_ready combinationally in the same cycle.
  - Latch op/x/y/id into alu_op/alu_x/alu_y/rsp_id.
  - Load cnt = MUL_LATENCY-1 for op 0x02, else 0.
  - Go to EXEC.
- Arbitration: round-robin.
  - A single valid requester is granted immediately.
  - When both are valid, grant the requester not granted last.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - At most one ready is asserted per cycle; ready is never asserted outside IDLE.
- EXEC: alu_* stay constant.
  - cnt != 0: decrement.
  - cnt == 0: capture rsp_w/rsp_cmp and go to RESP.
- Capture rules:
  - Compare ops 0x09/0x0A/0x0B: rsp_w = 0, rsp_cmp = alu_cmp.
  - All other ops: rsp_w = alu_w, rsp_cmp = 0.
  - MUL result is the low DATA_WIDTH bits.
- RESP: rsp_valid = 1 with rsp_* stable.
  - rsp_ready high: go to IDLE.
  - rsp_ready low: hold indefinitely, grant no new requests.
- alu_* retain their last values in IDLE and RESP.
- Reset mid-operation: FSM returns to IDLE. Any in-flight transaction is dropped and produces no response.
- Reset values:
  - rsp_valid, rsp_id, rsp_cmp, rsp_err, busy = 0
  - rsp_w, alu_x, alu_y = 0
  - alu_op = 0x00
  - req0_ready, req1_ready forced 0 while rst_n is low

## Timing
- Request handshake in cycle T (valid & ready high at edge T): EXEC starts T+1.
- Non-MUL: capture at edge T+1; rsp_valid high from T+2.
- MUL: rsp_valid high from T+1+MUL_LATENCY.
- Response handshake at edge R: IDLE in R+1; next grant earliest in R+1.
- Peak throughput, non-MUL with rsp_ready tied high: one op every 3 cycles.
- A requester may drop valid before ready without effect; once accepted, its inputs may change freely.
- rsp_ready is sampled only in RESP.

## Configuration
- ALU_ARB_ILLEGAL_OP_EN:
  - Defined: opcodes outside {0x00–0x07, 0x09–0x0C} are detected at accept.
    - EXEC is skipped (IDLE → RESP next cycle).
    - rsp_w = 0, rsp_cmp = 0, rsp_err = 1.
  - Undefined: every opcode executes normally; rsp_err is tied 0.

## Test plan
- Reset, then req0 ADD x=5 y=7 → ready same cycle; rsp_valid 2 cycles later with rsp_w=12, rsp_id=0, rsp_cmp=0.
- req1 MUL x=0x10000 y=0x10000, MUL_LATENCY=3 → rsp_w=0x0 (truncated), rsp_id=1, rsp_valid exactly 4 cycles after accept.
- Both valid every cycle, ops SUB 9−4 and LT 3<8 → grants alternate 0,1,0,1; responses rsp_w=5/rsp_cmp=0 and rsp_w=0/rsp_cmp=1.
- rsp_ready held low 10 cycles while req0 valid → rsp_* stable; req0_ready stays 0 until one cycle after rsp_ready rises.
- Assert rst_n low during MUL EXEC → all outputs return to reset values; no response appears after release.
- Op 0x0D with ALU_ARB_ILLEGAL_OP_EN defined → rsp_err=1, rsp_w=0, rsp_valid 1 cycle after accept. Without the macro → rsp_err=0.
